// File: rtl/m_uart_rx_pkg.sv
// rtl/m_uart_rx_pkg.sv - shared UART encodings: receiver states and bus bit positions
package m_uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Status bits returned on DAT_O
    localparam int DO_VALID = 8;
    localparam int DO_FERR  = 9;
    localparam int DO_OVR   = 10;

    // Control bits taken from DAT_I on a write
    localparam int DI_CLRFERR = 9;
    localparam int DI_CLROVR  = 10;
    localparam int DI_FLUSH   = 11;

endpackage

// File: rtl/m_uart_rx_if.sv
// rtl/m_uart_rx_if.sv - Wishbone IO responder bundle for the UART receiver
interface m_uart_rx_if;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (output STB_I, WE_I, DAT_I, input DAT_O, ACK_O);
    modport slave  (input STB_I, WE_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/m_uart_rxfifo.sv
// rtl/m_uart_rxfifo.sv - synchronous byte FIFO; a pop frees a slot for a same-cycle push when full
module m_uart_rxfifo #(
    parameter int AW = 2
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [7:0]    data_i,
    output logic [7:0]    head_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          pop_en;
    logic          push_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];
    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    always_ff @(posedge clk_i) begin
        if (!rstn_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_en) wptr_q <= wptr_q + 1'b1;
            if (pop_en)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
        end
    end

    // When full, wptr equals rptr: the popped head slot is the one overwritten
    always_ff @(posedge clk_i) begin
        if (push_en && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/m_uart_rx.sv
// rtl/m_uart_rx.sv - 8N1 UART receiver with byte FIFO behind a zero-wait Wishbone responder
module m_uart_rx
    import m_uart_rx_pkg::*;
#(
    parameter int CLKDIV = 104,
    parameter int FIFOAW = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        usartRX,
    m_uart_rx_if.slave  wb
);
    localparam logic [11:0] HALF_CNT = 12'(CLKDIV/2 - 1);
    localparam logic [11:0] BIT_CNT  = 12'(CLKDIV - 1);

    logic [1:0]  sync_q;
    logic [1:0]  vld_q;
    logic        rxs_d_q;
    logic        armed_q;
    rx_state_e   state_q;
    logic [11:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shreg_q;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic        rxs, start, push, rd, wr, pop, flush;
    logic [7:0]  head;
    logic        full, empty;
    logic [FIFOAW:0] fifo_count_unused;
    logic [31:0] dat_o;
    logic        unused_dat;

    assign rxs   = sync_q[1];
    // Only a high level seen on the real pin arms start detection, so a line
    // held low across reset release cannot fake a start edge.
    assign start = armed_q & rxs_d_q & ~rxs;
    assign push  = (state_q == ST_STOP) && (cnt_q == '0);
    assign rd    = wb.STB_I & ~wb.WE_I;
    assign wr    = wb.STB_I & wb.WE_I;
    assign pop   = rd & ~empty;
    assign flush = wr & wb.DAT_I[DI_FLUSH];

    assign ferr_d = (push & ~rxs) | (ferr_q & ~(wr & wb.DAT_I[DI_CLRFERR]));
    assign ovr_d  = (push & full & ~pop) | (ovr_q & ~(wr & wb.DAT_I[DI_CLROVR]));

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            sync_q  <= 2'b11;
            vld_q   <= 2'b00;
            rxs_d_q <= 1'b1;
            armed_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], usartRX};
            vld_q   <= {vld_q[0], 1'b1};
            rxs_d_q <= rxs;
            armed_q <= armed_q | (vld_q[1] & rxs);
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_START;
                    cnt_q   <= HALF_CNT;
                end
                ST_START: if (cnt_q == '0) begin
                    state_q <= rxs ? ST_IDLE : ST_DATA;
                    cnt_q   <= BIT_CNT;
                    bit_q   <= '0;
                end else cnt_q <= cnt_q - 1'b1;
                ST_DATA: if (cnt_q == '0) begin
                    shreg_q <= {rxs, shreg_q[7:1]};
                    cnt_q   <= BIT_CNT;
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == 3'd7) state_q <= ST_STOP;
                end else cnt_q <= cnt_q - 1'b1;
                ST_STOP: if (cnt_q == '0) state_q <= ST_IDLE;
                         else cnt_q <= cnt_q - 1'b1;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    m_uart_rxfifo #(.AW(FIFOAW)) u_fifo (
        .clk_i   (CLK_I),
        .rstn_i  (RST_I),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (shreg_q),
        .head_o  (head),
        .count_o (fifo_count_unused),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        dat_o = '0;
        if (RST_I && wb.STB_I) begin
            dat_o[7:0]     = empty ? 8'h00 : head;
            dat_o[DO_VALID] = ~empty;
            dat_o[DO_FERR]  = ferr_q;
            dat_o[DO_OVR]   = ovr_q;
        end
    end

    assign wb.DAT_O   = dat_o;
    assign wb.ACK_O   = wb.STB_I;
    assign unused_dat = ^{wb.DAT_I[31:12], wb.DAT_I[8:0]};

endmodule

// File: tb/tb_m_uart_rx.sv
// tb/tb_m_uart_rx.sv - scoreboard bench for m_uart_rx at CLKDIV=8, depth 4
module tb_m_uart_rx;
    localparam int CLKDIV = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    m_uart_rx_if bus ();

    m_uart_rx #(.CLKDIV(CLKDIV), .FIFOAW(2)) dut (
        .CLK_I   (clk),
        .RST_I   (rstn),
        .usartRX (rx),
        .wb      (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.STB_I && !bus.WE_I) begin
            n_cmp++;
            if (bus.ACK_O !== 1'b1) begin
                n_bad++;
                $display("FAIL ack got=%b want=1", bus.ACK_O);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read got=0x%03h want=none", bus.DAT_O);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.DAT_O !== exp_v) begin
                    n_bad++;
                    $display("FAIL read got=0x%03h want=0x%03h", bus.DAT_O, exp_v);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_read(input logic [31:0] e);
        @(posedge clk); #1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.STB_I = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] d);
        @(posedge clk); #1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.DAT_I = d;
        @(posedge clk); #1;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.DAT_I = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CLKDIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CLKDIV);
        end
        rx = stop;
        tick(CLKDIV);
        rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.DAT_I = '0;
        tick(2);
        wb_read(32'h000);
        tick(1);
        rstn = 1'b1;
        tick(5);
        wb_read(32'h000);

        send_frame(8'hA5, 1'b1);
        tick(3);
        n_cmp++;
        if (bus.DAT_O !== 32'h0) begin
            n_bad++;
            $display("FAIL dat_o_idle got=0x%03h want=0x000", bus.DAT_O);
        end
        wb_read(32'h1A5);
        wb_read(32'h000);

        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        tick(3);
        wb_read(32'h501);
        wb_read(32'h502);
        wb_read(32'h503);
        wb_read(32'h504);
        wb_read(32'h400);
        wb_write(32'h400);
        wb_read(32'h000);

        send_frame(8'h3C, 1'b0);
        tick(3);
        wb_read(32'h33C);
        wb_write(32'h200);
        wb_read(32'h000);

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        wb_read(32'h000);
        send_frame(8'h55, 1'b1);
        tick(3);
        wb_read(32'h155);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(3);
        wb_write(32'h800);
        wb_read(32'h000);

        // Fill, then land a pop exactly on the stop-bit sample edge (79 cycles after start)
        for (int b = 0; b < 4; b++) send_frame(8'h10 + 8'(b), 1'b1);
        tick(4);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (77) @(posedge clk);
                wb_read(32'h110);
            end
        join
        tick(3);
        wb_read(32'h111);
        wb_read(32'h112);
        wb_read(32'h113);
        wb_read(32'h199);
        wb_read(32'h000);

        rx = 1'b0;
        tick(CLKDIV * 5 + CLKDIV / 2);
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(10);
        rx = 1'b1;
        tick(40);
        wb_read(32'h000);
        send_frame(8'h81, 1'b1);
        tick(3);
        wb_read(32'h181);

        tick(5);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_reads got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
